// File: rtl/generation_sequencer.sv
// Sequences one Conway grid generation: snapshot, per-row settle and write strobe, completion.
// Optional macro GEN_SEQ_AUTORUN_EN: START seen in FINISH chains straight into the next SNAP.
module generation_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned GEN_WIDTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 HALT,
    output logic [1:0]           ROW_SEL,
    output logic                 ROW_WR_EN,
    output logic                 SNAPSHOT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [GEN_WIDTH-1:0] GEN_COUNT
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range_err
        $error("SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [2:0] {StIdle, StSnap, StSettle, StWrite, StFinish} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e               state_q, state_d;
    logic [3:0]           settle_cnt_q, settle_cnt_d;
    logic [1:0]           row_sel_q, row_sel_d;
    logic                 row_wr_en_q, row_wr_en_d;
    logic                 snapshot_q, snapshot_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [GEN_WIDTH-1:0] gen_count_q, gen_count_d;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        row_sel_d    = row_sel_q;
        gen_count_d  = gen_count_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d      = StSnap;
                    row_sel_d    = 2'd0;
                    settle_cnt_d = 4'd0;
                end
            end
            StSnap: begin
                state_d      = StSettle;
                settle_cnt_d = 4'd0;
            end
            StSettle: begin
                if (!HALT) begin
                    if (settle_cnt_q == SettleLast) begin
                        state_d = StWrite;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
            end
            StWrite: begin
                if (!HALT) begin
                    if (row_sel_q == 2'd3) begin
                        state_d     = StFinish;
                        gen_count_d = gen_count_q + GEN_WIDTH'(1);
                    end else begin
                        state_d      = StSettle;
                        row_sel_d    = row_sel_q + 2'd1;
                        settle_cnt_d = 4'd0;
                    end
                end
            end
            StFinish: begin
`ifdef GEN_SEQ_AUTORUN_EN
                if (START) begin
                    state_d      = StSnap;
                    row_sel_d    = 2'd0;
                    settle_cnt_d = 4'd0;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it.
        snapshot_d  = (state_d == StSnap);
        row_wr_en_d = (state_d == StWrite);
        done_d      = (state_d == StFinish);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            settle_cnt_q <= 4'd0;
            row_sel_q    <= 2'd0;
            row_wr_en_q  <= 1'b0;
            snapshot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            gen_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            row_sel_q    <= row_sel_d;
            row_wr_en_q  <= row_wr_en_d;
            snapshot_q   <= snapshot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            gen_count_q  <= gen_count_d;
        end
    end

    // A HALT raised while in WRITE must suppress the strobe already registered for this cycle;
    // the held WRITE state re-presents it once HALT drops.
    assign ROW_WR_EN = row_wr_en_q & ~HALT;
    assign ROW_SEL   = row_sel_q;
    assign SNAPSHOT  = snapshot_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign GEN_COUNT = gen_count_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Scoreboard bench for generation_sequencer (SETTLE_CYCLES=2, GEN_WIDTH=2) with a 2-to-4 decoder model.
module tb_generation_sequencer;

    localparam int GW = 2;
    localparam int KSnap  = 0;
    localparam int KWrite = 1;
    localparam int KDone  = 2;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n, start, halt;
    logic [1:0]    row_sel;
    logic          row_wr_en, snapshot, busy, done;
    logic [GW-1:0] gen_count;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t sb[$];

    generation_sequencer #(
        .SETTLE_CYCLES(2),
        .GEN_WIDTH    (GW)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .START    (start),
        .HALT     (halt),
        .ROW_SEL  (row_sel),
        .ROW_WR_EN(row_wr_en),
        .SNAPSHOT (snapshot),
        .BUSY     (busy),
        .DONE     (done),
        .GEN_COUNT(gen_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected finish", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int kind, input int val);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Undisturbed generation whose SNAPSHOT lands at cycle s.
    task automatic push_gen(input int s, input int gen);
        push(s, KSnap, 0);
        for (int r = 0; r < 4; r++) push(s + 3 * (r + 1), KWrite, r);
        push(s + 13, KDone, gen);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_sel"}, int'(row_sel), 0);
        chk({tag, "_row_wr_en"}, int'(row_wr_en), 0);
        chk({tag, "_snapshot"}, int'(snapshot), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_gen_count"}, int'(gen_count), 0);
    endtask

    task automatic match(input int kind, input int val);
        ev_t  e;
        logic [3:0] gated, want;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL ev_unexpected cyc=%0d kind=%0d val=%0d expected no event", cyc, kind, val);
        end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL ev_match actual cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         cyc, kind, val, e.cyc, e.kind, e.val);
            end else if (kind == KWrite) begin
                gated = (4'b0001 << row_sel) & {4{row_wr_en}};
                want  = 4'b0001 << e.val;
                if (gated != want) begin
                    failures++;
                    $display("FAIL dec_gate cyc=%0d actual=%b expected=%b", cyc, gated, want);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (snapshot === 1'b1) match(KSnap, int'(row_sel));
        if (row_wr_en === 1'b1) match(KWrite, int'(row_sel));
        if (done === 1'b1) match(KDone, int'(gen_count));
    end

    initial begin
        int b;
        int gseq[5];
        gseq = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        start = 1'b1;
        halt  = 1'b0;

        // Reset held two cycles with START high, then one cycle released without START.
        step();
        chk_reset_vals("rst_c1");
        step();
        chk_reset_vals("rst_c2");
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk_reset_vals("rst_rel");

        // Single generation; stray START at offset 6 must be ignored.
        b = cyc;
        start = 1'b1;
        push_gen(b + 1, 1);
        goto(b + 1);
        start = 1'b0;
        chk("single_busy_snap", int'(busy), 1);
        goto(b + 6);
        start = 1'b1;
        goto(b + 7);
        start = 1'b0;
        goto(b + 14);
        chk("single_busy_done", int'(busy), 1);
        goto(b + 15);
        chk("single_busy_idle", int'(busy), 0);
        goto(b + 17);
        chk("single_drained", sb.size(), 0);

        // HALT during SETTLE for cycles 5..8.
        b = cyc;
        start = 1'b1;
        push(b + 1, KSnap, 0);
        push(b + 4, KWrite, 0);
        push(b + 11, KWrite, 1);
        push(b + 14, KWrite, 2);
        push(b + 17, KWrite, 3);
        push(b + 18, KDone, 2);
        goto(b + 1);
        start = 1'b0;
        goto(b + 5);
        halt = 1'b1;
        goto(b + 9);
        halt = 1'b0;
        goto(b + 18);
        chk("halt_busy_done", int'(busy), 1);
        goto(b + 19);
        chk("halt_busy_idle", int'(busy), 0);

        // HALT in IDLE and SNAP ignored; HALT in a WRITE cycle suppresses and delays the strobe.
        b = cyc;
        start = 1'b1;
        halt  = 1'b1;
        push(b + 1, KSnap, 0);
        push(b + 5, KWrite, 0);
        push(b + 8, KWrite, 1);
        push(b + 11, KWrite, 2);
        push(b + 14, KWrite, 3);
        push(b + 15, KDone, 3);
        goto(b + 1);
        start = 1'b0;
        goto(b + 2);
        halt = 1'b0;
        goto(b + 4);
        halt = 1'b1;
        goto(b + 5);
        halt = 1'b0;
        goto(b + 17);

        // START held continuously across two generations; GEN_COUNT wraps 3 -> 0.
        b = cyc;
        start = 1'b1;
        push_gen(b + 1, 0);
`ifdef GEN_SEQ_AUTORUN_EN
        push_gen(b + 15, 1);
        for (int k = 1; k <= 28; k++) begin
            goto(b + k);
            chk("cont_busy_high", int'(busy), 1);
            if (k == 16) start = 1'b0;
        end
        goto(b + 29);
        chk("cont_busy_end", int'(busy), 0);
`else
        push_gen(b + 16, 1);
        goto(b + 14);
        chk("cont_busy_done", int'(busy), 1);
        goto(b + 15);
        chk("cont_busy_gap", int'(busy), 0);
        goto(b + 16);
        start = 1'b0;
        goto(b + 30);
        chk("cont_busy_end", int'(busy), 0);
`endif
        goto(cyc + 2);

        // Synchronous reset in the middle of a generation.
        b = cyc;
        start = 1'b1;
        push(b + 1, KSnap, 0);
        push(b + 4, KWrite, 0);
        push(b + 7, KWrite, 1);
        goto(b + 1);
        start = 1'b0;
        goto(b + 8);
        rst_n = 1'b0;
        goto(b + 9);
        rst_n = 1'b1;
        chk_reset_vals("midrst");
        goto(b + 22);
        chk("midrst_gen_count", int'(gen_count), 0);
        chk("midrst_drained", sb.size(), 0);

        // Five back-to-back generations through the decoder model; 2-bit count wraps.
        for (int k = 0; k < 5; k++) begin
            b = cyc;
            start = 1'b1;
            push_gen(b + 1, gseq[k]);
            goto(b + 1);
            start = 1'b0;
            goto(b + 15);
        end

        goto(cyc + 3);
        chk("final_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
